// File: rtl/dsp_pkg.sv
// dsp_pkg: shared OPMODE codes, widths and result record for the DSP48A1 MAC sequencer
// Ports: none (package)
package dsp_pkg;
    localparam int A_W   = 18;
    localparam int P_W   = 48;
    localparam int TAG_W = 8;
    // OPMODE bits 4-7 stay 0: no pre-adder, carry-in or post-subtract
    localparam logic [7:0] OPM_MUL  = 8'h01;
    localparam logic [7:0] OPM_MAC  = 8'h09;
    localparam logic [7:0] OPM_HOLD = 8'h08;
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [P_W-1:0]   data;
    } res_t;
endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// dsp_mac_sequencer_if: operand, slice-drive and result signals of the MAC sequencer
// Ports: s_valid/s_ready/s_a/s_b operand handshake; dsp_a/dsp_b/dsp_opmode/dsp_p slice link;
//        r_valid/r_ready/r_data/r_tag result handshake. slave = sequencer side, master = environment side.
interface dsp_mac_sequencer_if;
    import dsp_pkg::*;
    logic             s_valid;
    logic             s_ready;
    logic [A_W-1:0]   s_a;
    logic [A_W-1:0]   s_b;
    logic [A_W-1:0]   dsp_a;
    logic [A_W-1:0]   dsp_b;
    logic [7:0]       dsp_opmode;
    logic [P_W-1:0]   dsp_p;
    logic             r_valid;
    logic             r_ready;
    logic [P_W-1:0]   r_data;
    logic [TAG_W-1:0] r_tag;
    modport slave (
        input  s_valid, s_a, s_b, dsp_p, r_ready,
        output s_ready, dsp_a, dsp_b, dsp_opmode, r_valid, r_data, r_tag
    );
    modport master (
        output s_valid, s_a, s_b, dsp_p, r_ready,
        input  s_ready, dsp_a, dsp_b, dsp_opmode, r_valid, r_data, r_tag
    );
endinterface

// File: rtl/dsp_res_fifo.sv
// dsp_res_fifo: 2-entry result FIFO (48-bit data + 8-bit tag) with registered count
// Ports: clk, rst_n (async, active low); push/din write; pop read; dout head entry; full/empty flags
module dsp_res_fifo
    import dsp_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  res_t din,
    output res_t dout,
    output logic full,
    output logic empty
);
    res_t       mem [2];
    logic       wr, rd, push_ok, pop_ok;
    logic [1:0] count;
    assign full    = count == 2'd2;
    assign empty   = count == 2'd0;
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr     <= 1'b0;
            rd     <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem[wr] <= din;
                wr      <= ~wr;
            end
            if (pop_ok) rd <= ~rd;
            count <= count + 2'(push_ok) - 2'(pop_ok);
        end
    end
endmodule

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: drives DSP48A1 A/B/OPMODE to accumulate N_TAPS products and buffers each dot product
// Ports: clk, rst_n (async, active low); bus (slave modport): operand handshake, slice drive and P, tagged result handshake
module dsp_mac_sequencer
    import dsp_pkg::*;
#(
    parameter int N_TAPS  = 4,
    parameter int LAT     = 3,
    parameter int OPM_DLY = 1
) (
    input logic                clk,
    input logic                rst_n,
    dsp_mac_sequencer_if.slave bus
);
    localparam int TW = N_TAPS > 1 ? $clog2(N_TAPS) : 1;
    logic [TW-1:0]           tap;
    logic [OPM_DLY-1:0][7:0] opm_q;
    logic [LAT-1:0]          mark;
    logic [TAG_W-1:0]        tag;
    logic                    run, last, issue, credit, cap, full, empty;
    logic [7:0]              opm_in, inflight, level;
    res_t                    din, head;
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) inflight = inflight + 8'(mark[i]);
    end
    assign level = full ? 8'd2 : (empty ? 8'd0 : 8'd1);
    assign last  = tap == TW'(N_TAPS - 1);
    // every closing tap already in the slice pipeline owns a FIFO slot
    assign credit = level + inflight < 8'd2;
    // run keeps S_READY low while in reset and rises on the first edge after release
    assign bus.s_ready = run & (~last | credit);
    assign issue       = bus.s_valid & bus.s_ready;
    assign bus.dsp_a   = issue ? bus.s_a : '0;
    assign bus.dsp_b   = issue ? bus.s_b : '0;
    // idle cycles feed HOLD so P survives bubbles
    assign opm_in         = !issue ? OPM_HOLD : (tap == '0 ? OPM_MUL : OPM_MAC);
    assign bus.dsp_opmode = opm_q[OPM_DLY-1];
    // marker exit coincides with P holding the finished sum
    assign cap = mark[LAT-1];
    assign din = '{tag: tag, data: bus.dsp_p};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run   <= 1'b0;
            tap   <= '0;
            opm_q <= {OPM_DLY{OPM_HOLD}};
            mark  <= '0;
            tag   <= '0;
        end else begin
            run <= 1'b1;
            if (issue) tap <= last ? '0 : tap + TW'(1);
            opm_q <= (OPM_DLY * 8)'({opm_q, opm_in});
            mark  <= LAT'({mark, issue & last});
            tag   <= tag + TAG_W'(cap);
        end
    end
    dsp_res_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cap),
        .pop   (bus.r_valid & bus.r_ready),
        .din   (din),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );
    assign bus.r_valid = ~empty;
    assign bus.r_data  = head.data;
    assign bus.r_tag   = head.tag;
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb_dsp_mac_sequencer: directed bench with a DSP48A1 slice model (A1/B1/M/P/OPMODE regs) behind each sequencer
module tb_dsp_mac_sequencer;
    logic        clk = 0, rst_n = 0, s_valid = 0, r_ready = 1, sel = 0, s_ready_sel;
    logic [17:0] s_a = 0, s_b = 0;
    int          total = 0, passed = 0, fails = 0, stalls = 0;
    logic [55:0] q0[$], q1[$];

    always #5 clk = ~clk;

    dsp_mac_sequencer_if bus0 ();
    dsp_mac_sequencer_if bus1 ();

    dsp_mac_sequencer #(.N_TAPS(4), .LAT(3), .OPM_DLY(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    dsp_mac_sequencer #(.N_TAPS(1), .LAT(3), .OPM_DLY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    assign bus0.s_valid = s_valid;
    assign bus0.s_a     = s_a;
    assign bus0.s_b     = s_b;
    assign bus0.r_ready = r_ready;
    assign bus1.s_valid = s_valid;
    assign bus1.s_a     = s_a;
    assign bus1.s_b     = s_b;
    assign bus1.r_ready = r_ready;
    assign s_ready_sel  = sel ? bus1.s_ready : bus0.s_ready;

    function automatic logic signed [47:0] post(input logic [7:0] o, input logic signed [47:0] m, p);
        return ((o[1:0] == 2'b01) ? m : 48'sd0) + ((o[3:2] == 2'b10) ? p : 48'sd0);
    endfunction

    logic signed [17:0] a0r = 0, b0r = 0, a1r = 0, b1r = 0;
    logic signed [47:0] m0 = 0, p0 = 0, m1 = 0, p1 = 0;
    logic [7:0]         o0r = 8'h08, o1r = 8'h08;
    always @(posedge clk) begin
        a0r <= bus0.dsp_a;
        b0r <= bus0.dsp_b;
        m0  <= a0r * b0r;
        o0r <= bus0.dsp_opmode;
        p0  <= post(o0r, m0, p0);
        a1r <= bus1.dsp_a;
        b1r <= bus1.dsp_b;
        m1  <= a1r * b1r;
        o1r <= bus1.dsp_opmode;
        p1  <= post(o1r, m1, p1);
    end
    assign bus0.dsp_p = p0;
    assign bus1.dsp_p = p1;

    always @(posedge clk) begin
        if (bus0.r_valid & bus0.r_ready) q0.push_back({bus0.r_tag, bus0.r_data});
        if (bus1.r_valid & bus1.r_ready) q1.push_back({bus1.r_tag, bus1.r_data});
    end

    task automatic chk(input string t, input logic signed [63:0] obs, exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", t, obs, exp);
        end
    endtask

    task automatic send(input int a, b);
        int n = 0;
        @(negedge clk);
        s_valid = 1;
        s_a = 18'(a);
        s_b = 18'(b);
        while (!s_ready_sel && n < 100) begin
            @(negedge clk);
            n++;
        end
        stalls += n;
        if (n >= 100) chk("send_timeout", 64'(n), 0);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_valid = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        s_valid = 0;
        rst_n = 0;
        #1;
        chk("rst_s_ready", 64'(bus0.s_ready), 0);
        chk("rst_r_valid", 64'(bus0.r_valid), 0);
        chk("rst_r_data", $signed(bus0.r_data), 0);
        chk("rst_r_tag", 64'(bus0.r_tag), 0);
        chk("rst_opmode", 64'(bus0.dsp_opmode), 8);
        @(negedge clk);
        rst_n = 1;
        r_ready = 1;
        @(negedge clk);
        chk("post_rst_s_ready", 64'(bus0.s_ready), 1);
        q0.delete();
        q1.delete();
        stalls = 0;
    endtask

    task automatic chk_res(input string t, input logic [55:0] e, input int data, tag);
        chk({t, "_data"}, $signed(e[47:0]), 64'(data));
        chk({t, "_tag"}, 64'(e[55:48]), 64'(tag));
    endtask

    initial begin
        // basic
        do_reset();
        send(1, 2);
        send(3, 4);
        send(5, 6);
        send(7, 8);
        @(negedge clk);
        s_valid = 0;
        chk("basic_rv_c1", 64'(bus0.r_valid), 0);
        for (int i = 2; i <= 5; i++) begin
            @(negedge clk);
            chk("basic_rv_pulse", 64'(bus0.r_valid), (i == 4) ? 1 : 0);
            if (i == 4) begin
                chk("basic_data", $signed(bus0.r_data), 100);
                chk("basic_tag", 64'(bus0.r_tag), 0);
            end
        end
        chk("basic_count", 64'(q0.size()), 1);

        // signed operands with two bubble cycles between pairs
        q0.delete();
        send(-3, 7);
        idle(2);
        send(2, -5);
        idle(2);
        send(100, 100);
        idle(2);
        send(0, 9);
        idle(8);
        chk("bub_count", 64'(q0.size()), 1);
        if (q0.size() > 0) chk_res("bub", q0[0], 9969, 1);

        // streaming three dot products with no gap
        do_reset();
        for (int i = 0; i < 4; i++) send(1, 1);
        for (int i = 0; i < 4; i++) send(2, 2);
        for (int i = 0; i < 4; i++) send(-1, 1);
        idle(8);
        chk("stream_stalls", 64'(stalls), 0);
        chk("stream_count", 64'(q0.size()), 3);
        if (q0.size() == 3) begin
            chk_res("stream0", q0[0], 4, 0);
            chk_res("stream1", q0[1], 16, 1);
            chk_res("stream2", q0[2], -4, 2);
        end

        // backpressure: third closing tap must wait for a free slot
        do_reset();
        r_ready = 0;
        for (int i = 0; i < 11; i++) send(1, 1);
        chk("bp_no_early_stall", 64'(stalls), 0);
        @(negedge clk);
        s_valid = 1;
        s_a = 18'd1;
        s_b = 18'd1;
        chk("bp_stall", 64'(bus0.s_ready), 0);
        @(negedge clk);
        chk("bp_hold", 64'(bus0.s_ready), 0);
        r_ready = 1;
        chk("bp_ready_not_comb", 64'(bus0.s_ready), 0);
        @(negedge clk);
        r_ready = 0;
        chk("bp_rise", 64'(bus0.s_ready), 1);
        @(posedge clk);
        @(negedge clk);
        s_valid = 0;
        chk("bp_one_pop", 64'(q0.size()), 1);
        idle(6);
        r_ready = 1;
        idle(6);
        chk("bp_count", 64'(q0.size()), 3);
        if (q0.size() == 3) begin
            chk_res("bp0", q0[0], 4, 0);
            chk_res("bp1", q0[1], 4, 1);
            chk_res("bp2", q0[2], 4, 2);
        end

        // reset mid-sum with a buffered result pending
        do_reset();
        r_ready = 0;
        for (int i = 0; i < 4; i++) send(1, 1);
        idle(6);
        chk("mid_buffered", 64'(bus0.r_valid), 1);
        send(5, 5);
        send(5, 5);
        do_reset();
        send(1, 2);
        send(3, 4);
        send(5, 6);
        send(7, 8);
        idle(8);
        chk("mid_count", 64'(q0.size()), 1);
        if (q0.size() > 0) chk_res("mid", q0[0], 100, 0);

        // tag wrap with single-tap dot products
        do_reset();
        sel = 1;
        for (int i = 0; i < 257; i++) send(1, 1);
        idle(12);
        chk("wrap_count", 64'(q1.size()), 257);
        if (q1.size() == 257)
            for (int i = 0; i < 257; i++) chk_res("wrap", q1[i], 1, i % 256);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
